if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 17 +
 rtl/if_stage.sv | 116 +++++++++++
 tb/tb_if_stage.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

    typedef enum logic [1:0] {
        IF_IDLE,
        IF_FETCH,
        IF_HOLD,
        IF_DRAIN
    } if_state_e;

    localparam logic [31:0] IF_NOP = 32'h0000_0013;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC sequencing, stall holding, redirect draining.
// Optional macro IF_MISALIGN_CHECK_EN adds the FETCH_MISALIGN pulse output.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = IF_NOP
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_READY,
    input  logic [31:0] IMEM_RDATA,
    output logic        INSTR_VALID,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS_4
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic        FETCH_MISALIGN
`endif
);

    if_state_e   state;
    logic [31:0] pc_reg;
    logic [31:0] hold_buf;
    logic [31:0] drain_addr;
    logic [31:0] pc_next4;
    logic [31:0] target;

    assign pc_next4 = pc_reg + 32'd4;
    assign target   = align_pc(BRANCH_TARGET);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IF_IDLE;
            pc_reg     <= align_pc(RESET_PC);
            hold_buf   <= '0;
            drain_addr <= align_pc(RESET_PC);
        end else if (BRANCH_TAKEN) begin
            pc_reg <= target;
            case (state)
                // An outstanding request must still complete at its old address.
                IF_FETCH: begin
                    if (!IMEM_READY) begin
                        state      <= IF_DRAIN;
                        drain_addr <= pc_reg;
                    end else begin
                        state <= IF_FETCH;
                    end
                end
                IF_DRAIN: state <= IF_DRAIN;
                default:  state <= IF_FETCH;
            endcase
        end else begin
            unique case (state)
                IF_IDLE: state <= IF_FETCH;
                IF_FETCH: begin
                    if (IMEM_READY) begin
                        if (STALL) begin
                            hold_buf <= IMEM_RDATA;
                            state    <= IF_HOLD;
                        end else begin
                            pc_reg <= pc_next4;
                        end
                    end
                end
                IF_HOLD: begin
                    if (!STALL) begin
                        pc_reg <= pc_next4;
                        state  <= IF_FETCH;
                    end
                end
                IF_DRAIN: begin
                    if (IMEM_READY) begin
                        state <= IF_FETCH;
                    end
                end
                default: state <= IF_IDLE;
            endcase
        end
    end

    always_comb begin
        IMEM_REQ    = !RESET && ((state == IF_FETCH) || (state == IF_DRAIN));
        IMEM_ADDR   = (state == IF_DRAIN) ? drain_addr : pc_reg;
        INSTR_VALID = 1'b0;
        INSTRUCTION = NOP_INSTR;
        PC          = pc_reg;
        PC_PLUS_4   = pc_next4;
        if (!RESET && !BRANCH_TAKEN && !STALL) begin
            if ((state == IF_FETCH) && IMEM_READY) begin
                INSTR_VALID = 1'b1;
                INSTRUCTION = IMEM_RDATA;
            end else if (state == IF_HOLD) begin
                INSTR_VALID = 1'b1;
                INSTRUCTION = hold_buf;
            end
        end
    end

`ifdef IF_MISALIGN_CHECK_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            FETCH_MISALIGN <= 1'b0;
        end else begin
            FETCH_MISALIGN <= BRANCH_TAKEN && (BRANCH_TARGET[1:0] != 2'b00);
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized traffic against a program-order scoreboard.
`timescale 1ns/1ps
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        STALL = 1'b0;
    logic        BRANCH_TAKEN = 1'b0;
    logic [31:0] BRANCH_TARGET = '0;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_READY = 1'b0;
    logic [31:0] IMEM_RDATA = '0;
    logic        INSTR_VALID;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC;
    logic [31:0] PC_PLUS_4;
`ifdef IF_MISALIGN_CHECK_EN
    logic        FETCH_MISALIGN;
    logic        mis_pending = 1'b0;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;
    int          lat_cnt = 0;
    int          max_lat = 0;
    bit          started = 1'b0;
    int          rst_age = 0;
    int          delivered = 0;
    int          quiet = 0;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;

    always #5 CLK = ~CLK;

    if_stage #(
        .RESET_PC (RST_PC)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .STALL         (STALL),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .IMEM_REQ      (IMEM_REQ),
        .IMEM_ADDR     (IMEM_ADDR),
        .IMEM_READY    (IMEM_READY),
        .IMEM_RDATA    (IMEM_RDATA),
        .INSTR_VALID   (INSTR_VALID),
        .INSTRUCTION   (INSTRUCTION),
        .PC            (PC),
        .PC_PLUS_4     (PC_PLUS_4)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .FETCH_MISALIGN (FETCH_MISALIGN)
`endif
    );

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int new_lat();
        return (max_lat == 0) ? 0 : int'($urandom_range(max_lat, 0));
    endfunction

    // One cycle of stimulus; the expected program stream is updated as redirects are issued.
    task automatic drive(input bit rst, input bit stl, input bit br, input logic [31:0] tgt);
        @(posedge CLK);
        #1;
        RESET         = rst;
        STALL         = stl;
        BRANCH_TAKEN  = br;
        BRANCH_TARGET = tgt;
        if (rst) begin
            exp_q.delete();
            exp_q.push_back(RST_PC);
            lat_cnt = new_lat();
        end else if (br) begin
            exp_q.delete();
            exp_q.push_back(tgt & ~32'd3);
        end
        #1;
        if (IMEM_REQ) begin
            if (lat_cnt == 0) begin
                IMEM_READY = 1'b1;
                IMEM_RDATA = word_at(IMEM_ADDR);
                lat_cnt    = new_lat();
            end else begin
                IMEM_READY = 1'b0;
                IMEM_RDATA = $urandom;
                lat_cnt--;
            end
        end else begin
            // Stray responses with no request outstanding must be ignored.
            IMEM_READY = (max_lat != 0) && ($urandom_range(3, 0) == 0);
            IMEM_RDATA = $urandom;
        end
    endtask

    always @(negedge CLK) begin
        if (started) begin
            if (RESET) begin
                chkb("reset_req", IMEM_REQ, 1'b0);
                chkb("reset_valid", INSTR_VALID, 1'b0);
                chk("reset_instr", INSTRUCTION, IF_NOP);
                if (rst_age > 0) chk("reset_pc", PC, RST_PC);
                rst_age++;
                quiet     = 0;
                prev_wait = 1'b0;
            end else begin
                rst_age = 0;
                if (INSTR_VALID) begin
                    quiet = 0;
                    if (BRANCH_TAKEN) begin
                        chkb("valid_on_redirect", INSTR_VALID, 1'b0);
                    end else if (exp_q.size() == 0) begin
                        chkb("unexpected_valid", INSTR_VALID, 1'b0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("pc", PC, mon_e);
                        chk("instruction", INSTRUCTION, word_at(mon_e));
                        chk("pc_plus_4", PC_PLUS_4, mon_e + 32'd4);
                        delivered++;
                        if (exp_q.size() == 0) exp_q.push_back(mon_e + 32'd4);
                    end
                end else begin
                    quiet++;
                    chk("nop_when_invalid", INSTRUCTION, IF_NOP);
                    if (quiet > 80) begin
                        chk("progress_timeout", quiet, 0);
                        quiet = 0;
                    end
                end
                if (prev_wait && IMEM_REQ) chk("addr_stable", IMEM_ADDR, prev_addr);
                prev_wait = IMEM_REQ && !IMEM_READY;
                prev_addr = IMEM_ADDR;
            end
`ifdef IF_MISALIGN_CHECK_EN
            chkb("fetch_misalign", FETCH_MISALIGN, mis_pending);
            mis_pending = !RESET && BRANCH_TAKEN && (BRANCH_TARGET[1:0] != 2'b00);
`endif
        end
    end

    initial begin
        int          rst_left;
        logic [31:0] tgt;
        bit          r;
        bit          s;
        bit          b;

        started = 1'b1;
        max_lat = 0;
        repeat (3) drive(1, 0, 0, '0);

        // Back-to-back ready memory, then a three-cycle stall at PC 8.
        drive(0, 0, 0, '0);
        #1 chkb("d_idle_req", IMEM_REQ, 1'b0);
        drive(0, 0, 0, '0);
        #1 chk("d_addr0", IMEM_ADDR, 32'h0);
        chkb("d_valid_2nd", INSTR_VALID, 1'b1);
        drive(0, 0, 0, '0);
        #1 chk("d_addr4", IMEM_ADDR, 32'h4);
        drive(0, 1, 0, '0);
        #1 chk("d_addr8", IMEM_ADDR, 32'h8);
        chkb("d_stall_novalid", INSTR_VALID, 1'b0);
        drive(0, 1, 0, '0);
        drive(0, 1, 0, '0);
        #1 chkb("d_hold_noreq", IMEM_REQ, 1'b0);
        drive(0, 0, 0, '0);
        #1 chk("d_hold_word", INSTRUCTION, word_at(32'h8));
        drive(0, 0, 0, '0);
        #1 chk("d_after_hold", IMEM_ADDR, 32'hC);

        // Wrap at the top of the address space.
        drive(0, 0, 1, 32'hFFFF_FFFC);
        drive(0, 0, 0, '0);
        #1 chk("d_wrap_addr", IMEM_ADDR, 32'hFFFF_FFFC);
        chk("d_wrap_pc4", PC_PLUS_4, 32'h0);
        drive(0, 0, 0, '0);
        #1 chk("d_wrap_next", IMEM_ADDR, 32'h0);

        // Redirect while a request to 0x20 is outstanding.
        drive(0, 0, 1, 32'h20);
        lat_cnt = 2;
        drive(0, 0, 1, 32'h100);
        drive(0, 0, 0, '0);
        #1 chk("d_drain_addr", IMEM_ADDR, 32'h20);
        drive(0, 0, 0, '0);
        #1 chkb("d_drain_discard", INSTR_VALID, 1'b0);
        drive(0, 0, 0, '0);
        #1 chk("d_drain_next", IMEM_ADDR, 32'h100);

        // Redirect together with stall while holding.
        drive(0, 1, 0, '0);
        drive(0, 1, 1, 32'h40);
        drive(0, 0, 0, '0);
        #1 chk("d_hold_redirect", IMEM_ADDR, 32'h40);

        // Misaligned target has its low bits cleared.
        drive(0, 0, 1, 32'h102);
        drive(0, 0, 0, '0);
        #1 chk("d_misalign_addr", IMEM_ADDR, 32'h100);

        // Three-cycle memory latency straight out of reset.
        repeat (2) drive(1, 0, 0, '0);
        lat_cnt = 2;
        drive(0, 0, 0, '0);
        drive(0, 0, 0, '0);
        #1 chkb("d_lat_wait1", INSTR_VALID, 1'b0);
        drive(0, 0, 0, '0);
        #1 chkb("d_lat_wait2", INSTR_VALID, 1'b0);
        drive(0, 0, 0, '0);
        #1 chkb("d_lat_valid", INSTR_VALID, 1'b1);
        chk("d_lat_pc", PC, 32'h0);
        chk("d_lat_pc4", PC_PLUS_4, 32'h4);

        // Randomized traffic.
        max_lat  = 3;
        rst_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (rst_left > 0) begin
                r = 1'b1;
                rst_left--;
            end else begin
                r = ($urandom_range(99, 0) == 0);
                if (r) rst_left = 1;
            end
            s = ($urandom_range(3, 0) == 0);
            b = ($urandom_range(19, 0) == 0);
            case ($urandom_range(5, 0))
                0:       tgt = 32'hFFFF_FFFC;
                1:       tgt = 32'h0000_0102;
                2:       tgt = 32'h0000_0040;
                3:       tgt = 32'h0000_0100;
                default: tgt = $urandom;
            endcase
            drive(r, s, b, tgt);
        end
        repeat (4) drive(0, 0, 0, '0);
        #1 chkb("liveness", delivered > 200, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
